// File: rtl/clk_monitor_pkg.sv
// -----------------------------------------------------------------------------
// clk_monitor_pkg
// Shared definitions for the clock monitor: FSM state encoding, the default
// period-counter width and the synchronizer depth.
// -----------------------------------------------------------------------------
package clk_monitor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_MEASURE = 2'd2,
        ST_LOST    = 2'd3
    } state_e;

    localparam int unsigned DEFAULT_CNT_W = 16;
    localparam int unsigned SYNC_STAGES   = 2;

endpackage

// File: rtl/clk_monitor_sync_edge.sv
// -----------------------------------------------------------------------------
// clk_monitor_sync_edge
// Brings the asynchronous monitored clock into the clk domain and produces
// single-cycle rise/fall pulses. Without the filter an input transition shows
// up as a pulse 3 clk cycles later. With CLK_MONITOR_GLITCH_FILTER_EN defined,
// a synchronized level must be seen on 3 consecutive samples before it is
// accepted, giving 5 cycles of latency and rejecting pulses shorter than
// 3 cycles.
//
// Ports
//   clk     in   system clock
//   rst_n   in   asynchronous active-low reset
//   mon_in  in   monitored clock (asynchronous)
//   rise    out  one-cycle pulse on an accepted rising edge
//   fall    out  one-cycle pulse on an accepted falling edge
// -----------------------------------------------------------------------------
module clk_monitor_sync_edge
    import clk_monitor_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic mon_in,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   synced;
    logic                   level;
    logic                   level_prev_q, level_prev_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;

    assign synced = sync_q[SYNC_STAGES-1];

`ifdef CLK_MONITOR_GLITCH_FILTER_EN
    logic [1:0] hist_q, hist_d;

    // Accept the new level only once the current and two previous samples
    // agree; otherwise keep presenting the last accepted level.
    always_comb begin
        hist_d = {hist_q[0], synced};
        level  = level_prev_q;
        if ((synced == hist_q[0]) && (synced == hist_q[1])) begin
            level = synced;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= '0;
        end else begin
            hist_q <= hist_d;
        end
    end
`else
    assign level = synced;
`endif

    always_comb begin
        sync_d       = {sync_q[SYNC_STAGES-2:0], mon_in};
        level_prev_d = level;
        rise_d       = level & ~level_prev_q;
        fall_d       = ~level & level_prev_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q       <= '0;
            level_prev_q <= 1'b0;
            rise_q       <= 1'b0;
            fall_q       <= 1'b0;
        end else begin
            sync_q       <= sync_d;
            level_prev_q <= level_prev_d;
            rise_q       <= rise_d;
            fall_q       <= fall_d;
        end
    end

    assign rise = rise_q;
    assign fall = fall_q;

endmodule

// File: rtl/clk_monitor.sv
// -----------------------------------------------------------------------------
// clk_monitor
// Measures the rising-to-rising period of a slow monitored clock in clk
// cycles, flags periods outside [MIN_PERIOD, MAX_PERIOD] with sticky flags and
// declares the clock lost after TIMEOUT cycles without any edge.
// Optional glitch filter: define CLK_MONITOR_GLITCH_FILTER_EN.
//
// Ports
//   clk           in   system clock
//   rst_n         in   asynchronous active-low reset
//   mon_in        in   monitored clock (asynchronous, treated as data)
//   enable        in   1 = run, 0 = return to IDLE and clear counters
//   clr_flags     in   pulse, clears too_fast / too_slow
//   period        out  last measured period [CNT_W]
//   period_valid  out  one-cycle pulse when period updates
//   too_fast      out  sticky, a period below MIN_PERIOD was seen
//   too_slow      out  sticky, a period above MAX_PERIOD was seen
//   clk_lost      out  high while the monitored clock is considered lost
// -----------------------------------------------------------------------------
module clk_monitor
    import clk_monitor_pkg::*;
#(
    parameter int unsigned CNT_W      = DEFAULT_CNT_W,
    parameter int unsigned MIN_PERIOD = 4,
    parameter int unsigned MAX_PERIOD = 1000,
    parameter int unsigned TIMEOUT    = 2000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mon_in,
    input  logic             enable,
    input  logic             clr_flags,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             too_fast,
    output logic             too_slow,
    output logic             clk_lost
);

    localparam int unsigned      IDLE_W  = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDLE_W-1:0]  idle_q, idle_d;
    logic [CNT_W-1:0]   period_q, period_d;
    logic               period_valid_q, period_valid_d;
    logic               too_fast_q, too_fast_d;
    logic               too_slow_q, too_slow_d;

    logic               rise, fall;
    logic [CNT_W-1:0]   cnt_inc;
    logic [IDLE_W-1:0]  idle_inc;
    logic               timeout_hit;
    logic               is_fast, is_slow;

    clk_monitor_sync_edge u_sync_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .mon_in (mon_in),
        .rise   (rise),
        .fall   (fall)
    );

    always_comb begin
        cnt_inc     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        idle_inc    = idle_q + 1'b1;
        timeout_hit = (32'(idle_q) + 32'd1) >= TIMEOUT;
        is_fast     = 32'(cnt_q) < MIN_PERIOD;
        // A saturated counter means the true period is beyond what can be
        // represented, so it is treated as too slow as well.
        is_slow     = (32'(cnt_q) > MAX_PERIOD) || (cnt_q == CNT_MAX);
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        idle_d         = idle_q;
        period_d       = period_q;
        period_valid_d = 1'b0;
        too_fast_d     = too_fast_q;
        too_slow_d     = too_slow_q;

        // Clear first so that a same-cycle set below takes priority.
        if (clr_flags) begin
            too_fast_d = 1'b0;
            too_slow_d = 1'b0;
        end

        if (!enable) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            idle_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_ARM;
                    cnt_d   = '0;
                    idle_d  = '0;
                end
                ST_ARM: begin
                    if (rise) begin
                        state_d = ST_MEASURE;
                        cnt_d   = CNT_ONE;
                        idle_d  = '0;
                    end else if (fall) begin
                        idle_d = '0;
                    end else if (timeout_hit) begin
                        state_d = ST_LOST;
                        cnt_d   = '0;
                        idle_d  = '0;
                    end else begin
                        idle_d = idle_inc;
                    end
                end
                ST_MEASURE: begin
                    if (rise) begin
                        period_d       = cnt_q;
                        period_valid_d = 1'b1;
                        if (is_fast) too_fast_d = 1'b1;
                        if (is_slow) too_slow_d = 1'b1;
                        cnt_d          = CNT_ONE;
                        idle_d         = '0;
                    end else if (fall) begin
                        cnt_d  = cnt_inc;
                        idle_d = '0;
                    end else if (timeout_hit) begin
                        state_d = ST_LOST;
                        cnt_d   = '0;
                        idle_d  = '0;
                    end else begin
                        cnt_d  = cnt_inc;
                        idle_d = idle_inc;
                    end
                end
                ST_LOST: begin
                    cnt_d  = '0;
                    idle_d = '0;
                    if (rise) state_d = ST_ARM;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            idle_q         <= '0;
            period_q       <= '0;
            period_valid_q <= 1'b0;
            too_fast_q     <= 1'b0;
            too_slow_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            idle_q         <= idle_d;
            period_q       <= period_d;
            period_valid_q <= period_valid_d;
            too_fast_q     <= too_fast_d;
            too_slow_q     <= too_slow_d;
        end
    end

    assign period       = period_q;
    assign period_valid = period_valid_q;
    assign too_fast     = too_fast_q;
    assign too_slow     = too_slow_q;
    // Drops in the same cycle the recovering rising edge is seen.
    assign clk_lost     = (state_q == ST_LOST) && !rise;

endmodule

// File: tb/tb_clk_monitor.sv
// -----------------------------------------------------------------------------
// tb_clk_monitor
// Self-checking bench for clk_monitor: a 16-bit default instance and an 8-bit
// instance with TIMEOUT=400 for the saturation case.
// -----------------------------------------------------------------------------
module tb_clk_monitor;

`ifdef CLK_MONITOR_GLITCH_FILTER_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 3;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mon_in;
    logic        mon8;
    logic        enable;
    logic        clr_flags;

    logic [15:0] period;
    logic        period_valid, too_fast, too_slow, clk_lost;
    logic [7:0]  period8;
    logic        pv8, fast8, slow8, lost8;

    int total = 0;
    int bad   = 0;
    int exp_q[$];
    int exp8_q[$];

    typedef struct {
        int hi;
        int lo;
        int n;
        int exp_period;
        bit exp_fast;
        bit exp_slow;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    clk_monitor #(.CNT_W(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mon_in       (mon_in),
        .enable       (enable),
        .clr_flags    (clr_flags),
        .period       (period),
        .period_valid (period_valid),
        .too_fast     (too_fast),
        .too_slow     (too_slow),
        .clk_lost     (clk_lost)
    );

    clk_monitor #(.CNT_W(8), .TIMEOUT(400)) dut8 (
        .clk          (clk),
        .rst_n        (rst_n),
        .mon_in       (mon8),
        .enable       (enable),
        .clr_flags    (clr_flags),
        .period       (period8),
        .period_valid (pv8),
        .too_fast     (fast8),
        .too_slow     (slow8),
        .clk_lost     (lost8)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // One clock step; outputs are sampled 1 time unit after the rising edge
    // and any period_valid pulse is matched against the scoreboard.
    task automatic tick();
        @(posedge clk);
        #1;
        if (period_valid === 1'b1) begin
            if (exp_q.size() == 0) check("valid16_unexpected", {31'b0, period_valid}, 32'd0);
            else check("period16", {16'b0, period}, exp_q.pop_front());
        end
        if (pv8 === 1'b1) begin
            if (exp8_q.size() == 0) check("valid8_unexpected", {31'b0, pv8}, 32'd0);
            else check("period8", {24'b0, period8}, exp8_q.pop_front());
        end
    endtask

    task automatic drive_wave(input int hi, input int lo, input int n, input int exp, input bit sel8);
        for (int k = 0; k < n; k++) begin
            if (sel8) mon8 = 1'b1; else mon_in = 1'b1;
            if (k > 0) begin
                if (sel8) exp8_q.push_back(exp); else exp_q.push_back(exp);
            end
            repeat (hi) tick();
            if (sel8) mon8 = 1'b0; else mon_in = 1'b0;
            repeat (lo) tick();
        end
    endtask

    task automatic restart(input bit clr);
        enable = 1'b0;
        tick();
        tick();
        if (clr) begin
            clr_flags = 1'b1;
            tick();
            clr_flags = 1'b0;
        end
        enable = 1'b1;
        tick();
    endtask

    initial begin
        int last_period;
        bit prev_fast, prev_slow;

        vecs.push_back('{10, 10, 5, 20, 1'b0, 1'b0});
`ifndef CLK_MONITOR_GLITCH_FILTER_EN
        vecs.push_back('{1, 1, 3, 2, 1'b1, 1'b0});
        vecs.push_back('{2, 1, 3, 3, 1'b1, 1'b0});
        vecs.push_back('{2, 2, 3, 4, 1'b0, 1'b0});
`else
        vecs.push_back('{3, 3, 3, 6, 1'b0, 1'b0});
`endif
        vecs.push_back('{500, 500, 2, 1000, 1'b0, 1'b0});
        vecs.push_back('{500, 501, 2, 1001, 1'b0, 1'b1});
        vecs.push_back('{750, 750, 2, 1500, 1'b0, 1'b1});

        rst_n = 1'b0; mon_in = 1'b0; mon8 = 1'b0; enable = 1'b0; clr_flags = 1'b0;
        repeat (3) tick();
        check("rst_period",  {16'b0, period}, 32'd0);
        check("rst_valid",   {31'b0, period_valid}, 32'd0);
        check("rst_fast",    {31'b0, too_fast}, 32'd0);
        check("rst_slow",    {31'b0, too_slow}, 32'd0);
        check("rst_lost",    {31'b0, clk_lost}, 32'd0);
        check("rst_period8", {24'b0, period8}, 32'd0);
        rst_n = 1'b1;
        tick();

        last_period = 0;
        prev_fast   = 1'b0;
        prev_slow   = 1'b0;
        foreach (vecs[i]) begin
            enable = 1'b0;
            tick();
            tick();
            check("hold_period", {16'b0, period}, last_period);
            check("hold_fast", {31'b0, too_fast}, {31'b0, prev_fast});
            check("hold_slow", {31'b0, too_slow}, {31'b0, prev_slow});
            check("idle_lost", {31'b0, clk_lost}, 32'd0);
            clr_flags = 1'b1;
            tick();
            clr_flags = 1'b0;
            check("clr_fast", {31'b0, too_fast}, 32'd0);
            check("clr_slow", {31'b0, too_slow}, 32'd0);
            enable = 1'b1;
            tick();
            drive_wave(vecs[i].hi, vecs[i].lo, vecs[i].n, vecs[i].exp_period, 1'b0);
            repeat (8) tick();
            check("drain16", exp_q.size(), 32'd0);
            check("vec_fast", {31'b0, too_fast}, {31'b0, vecs[i].exp_fast});
            check("vec_slow", {31'b0, too_slow}, {31'b0, vecs[i].exp_slow});
            check("vec_period", {16'b0, period}, vecs[i].exp_period);
            last_period = vecs[i].exp_period;
            prev_fast   = vecs[i].exp_fast;
            prev_slow   = vecs[i].exp_slow;
        end

        // Loss of clock: one rise, one fall, then silence.
        restart(1'b0);
        mon_in = 1'b1;
        repeat (10) tick();
        mon_in = 1'b0;
        repeat (1990) tick();
        check("lost_before_timeout", {31'b0, clk_lost}, 32'd0);
        repeat (25) tick();
        check("lost_after_timeout", {31'b0, clk_lost}, 32'd1);
        check("lost_period_hold", {16'b0, period}, 32'd1500);
        mon_in = 1'b1;
        repeat (LAT) tick();
        check("lost_clear_edge_cycle", {31'b0, clk_lost}, 32'd0);
        repeat (2) tick();
        check("lost_clear_after", {31'b0, clk_lost}, 32'd0);
        mon_in = 1'b0;
        repeat (10) tick();

        // Reset during the low phase of a running measurement.
        drive_wave(10, 10, 3, 20, 1'b0);
        mon_in = 1'b1;
        exp_q.push_back(20);
        repeat (10) tick();
        mon_in = 1'b0;
        repeat (5) tick();
        rst_n = 1'b0;
        tick();
        tick();
        check("midrst_period", {16'b0, period}, 32'd0);
        check("midrst_valid",  {31'b0, period_valid}, 32'd0);
        check("midrst_fast",   {31'b0, too_fast}, 32'd0);
        check("midrst_slow",   {31'b0, too_slow}, 32'd0);
        check("midrst_lost",   {31'b0, clk_lost}, 32'd0);
        rst_n = 1'b1;
        repeat (5) tick();
        drive_wave(10, 10, 3, 20, 1'b0);
        repeat (8) tick();
        check("midrst_drain", exp_q.size(), 32'd0);
        check("midrst_period_after", {16'b0, period}, 32'd20);

        // 8-bit counter saturates on a 300-cycle period.
        restart(1'b1);
        drive_wave(150, 150, 3, 255, 1'b1);
        repeat (8) tick();
        check("drain8", exp8_q.size(), 32'd0);
        check("sat_period8", {24'b0, period8}, 32'd255);
        check("sat_slow8", {31'b0, slow8}, 32'd1);
        check("sat_fast8", {31'b0, fast8}, 32'd0);

`ifndef CLK_MONITOR_GLITCH_FILTER_EN
        // clr_flags lands in the very cycle the too-fast period is recorded.
        restart(1'b1);
        mon_in = 1'b1;
        tick();
        tick();
        mon_in = 1'b0;
        tick();
        mon_in = 1'b1;
        exp_q.push_back(3);
        tick();
        tick();
        mon_in = 1'b0;
        tick();
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        check("set_wins_over_clr", {31'b0, too_fast}, 32'd1);
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        check("clr_after_set", {31'b0, too_fast}, 32'd0);
        repeat (8) tick();
        check("drain_setclr", exp_q.size(), 32'd0);
`else
        // Single-cycle glitches in both phases of a period-20 clock.
        restart(1'b1);
        for (int k = 0; k < 5; k++) begin
            mon_in = 1'b1;
            if (k > 0) exp_q.push_back(20);
            repeat (5) tick();
            mon_in = 1'b0;
            tick();
            mon_in = 1'b1;
            repeat (4) tick();
            mon_in = 1'b0;
            repeat (5) tick();
            mon_in = 1'b1;
            tick();
            mon_in = 1'b0;
            repeat (4) tick();
        end
        repeat (8) tick();
        check("glitch_drain", exp_q.size(), 32'd0);
        check("glitch_fast", {31'b0, too_fast}, 32'd0);
        check("glitch_period", {16'b0, period}, 32'd20);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/clk_monitor.md
CLK_MONITOR -- requirements
Module: clk_monitor

Interface
REQ-001 Parameter CNT_W, default 16, width of the period counter and the period output.
REQ-002 Parameter MIN_PERIOD, default 4, smallest legal rising-to-rising period, in clk cycles.
REQ-003 Parameter MAX_PERIOD, default 1000, largest legal rising-to-rising period, in clk cycles.
REQ-004 Parameter TIMEOUT, default 2000, clk cycles without any mon_in edge before loss is declared.
REQ-005 clk  input  1  single system clock; all state changes on its rising edge.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 mon_in  input  1  monitored slow clock; asynchronous to clk, treated as data.
REQ-008 enable  input  1  high = monitor running; low = return to IDLE, clear counters.
REQ-009 period  output  CNT_W  last measured rising-to-rising period, in clk cycles.
REQ-010 period_valid  output  1  one-cycle pulse when period updates.
REQ-011 too_fast  output  1  sticky flag: a measured period was below MIN_PERIOD.
REQ-012 too_slow  output  1  sticky flag: a measured period was above MAX_PERIOD.
REQ-013 clk_lost  output  1  level; high while in LOST state.
REQ-014 clr_flags  input  1  single-cycle pulse; clears too_fast and too_slow.

Function
REQ-015 mon_in SHALL pass through a 2-flop synchronizer, then an edge detector; a rising or falling edge is detected 3 clk cycles after the mon_in transition.
REQ-016 FSM states: IDLE, ARM, MEASURE, LOST.
REQ-017 IDLE -> ARM when enable=1; ARM waits for the first rising edge, then -> MEASURE with the counter at 1.
REQ-018 In MEASURE, each detected rising edge SHALL load period with the counter value, pulse period_valid, and reset the counter to 1 in the same cycle.
REQ-019 The period counter SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.
REQ-020 On update: period<MIN_PERIOD sets too_fast; period>MAX_PERIOD sets too_slow; both flags are sticky.
REQ-021 An idle counter, reset on any edge (rising or falling), reaching TIMEOUT in ARM or MEASURE -> LOST; clk_lost=1; no period_valid.
REQ-022 LOST -> ARM on the next detected rising edge; clk_lost deasserts in that cycle; period holds its last value.
REQ-023 clr_flags in the same cycle as a flag-setting update: the set wins.
REQ-024 enable=0 in any state -> IDLE next cycle; counters cleared; period and the flags hold; clk_lost=0.

Reset
REQ-025 rst_n low: state=IDLE, period=0, period_valid=0, too_fast=0, too_slow=0, clk_lost=0, synchronizer flops=0, counters=0.
REQ-026 Reset mid-measurement discards the partial count; after release, the first rising edge only arms the monitor.

Configuration
REQ-027 Macro CLK_MONITOR_GLITCH_FILTER_EN defined: a synchronized level SHALL be accepted only after 3 consecutive equal samples, which adds 2 cycles of edge latency (5 total); pulses shorter than 3 clk cycles are ignored.
REQ-028 Macro undefined: no filter; edge latency is exactly 3 cycles as in REQ-015.

Structure
REQ-029 Package clk_monitor_pkg SHALL hold the FSM state enum, the default CNT_W, and SYNC_STAGES=2.
REQ-030 Sub-module clk_monitor_sync_edge SHALL contain the synchronizer, the optional glitch filter, and rise/fall edge pulses; the FSM and counters stay in clk_monitor.

Verification
REQ-031 Defaults, mon_in period 20 clk cycles, 5 periods -> 4 period_valid pulses, each with period=20; flags stay 0.
REQ-032 mon_in period 2 cycles (high 1, low 1) with macro undefined -> too_fast=1 after the second rising edge; clr_flags -> 0.
REQ-033 Period 1500 -> too_slow=1, period=1500; then mon_in held constant for 2000 cycles -> clk_lost=1; the next rising edge deasserts it.
REQ-034 CNT_W=8, period 300, TIMEOUT=400 -> period=255 (saturated), too_slow=1.
REQ-035 rst_n pulsed low mid-period, then period 20 resumed -> all outputs 0 during reset; the first valid period after release is 20.
REQ-036 Macro defined, 1-cycle glitches injected into a period-20 mon_in -> period stays 20, no too_fast.
